// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM/WB stage with a two-entry skid buffer, flush, x0 write
// suppression, forwarding lookup across held entries and a commit counter.
`default_nettype none

module mem_wb_skid #(
  parameter int unsigned            DATA_W   = 32,
  parameter int unsigned            ADDR_W   = 5,
  parameter logic [ADDR_W-1:0]      NOP_ADDR = '0,
  parameter int unsigned            CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_waddr,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  output logic [DATA_W-1:0] lk_data,
  output logic [CNT_W-1:0]  commit_cnt
);

  // State bits are {S.valid, H.valid}; 2'b10 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] h_wdata_q, h_wdata_d, s_wdata_q, s_wdata_d;
  logic              h_we_q, h_we_d, s_we_q, s_we_d;
  logic [ADDR_W-1:0] h_waddr_q, h_waddr_d, s_waddr_q, s_waddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic acc, ret, cap_we;
  logic h_vld, s_vld, h_hit, s_hit;

  assign h_vld  = state_q[0];
  assign s_vld  = state_q[1];
  assign acc    = in_valid & in_ready;
  assign ret    = out_valid & out_ready;
  assign cap_we = in_we & (in_waddr != '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides any accept or retire
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) state_d = ST_ONE;
        ST_ONE: begin
          if (acc && !ret)      state_d = ST_FULL;
          else if (!acc && ret) state_d = ST_EMPTY;
        end
        ST_FULL:  if (ret) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output decode from registered state only
  always_comb begin
    in_ready  = !s_vld;
    out_valid = h_vld;
    out_wdata = '0;
    out_we    = 1'b0;
    out_waddr = NOP_ADDR;
    if (h_vld) begin
      out_wdata = h_wdata_q;
      out_we    = h_we_q;
      out_waddr = h_waddr_q;
    end
  end

  always_comb begin
    h_wdata_d = h_wdata_q;
    h_we_d    = h_we_q;
    h_waddr_d = h_waddr_q;
    s_wdata_d = s_wdata_q;
    s_we_d    = s_we_q;
    s_waddr_d = s_waddr_q;
    if (!flush) begin
      if ((state_q == ST_EMPTY && acc) || (state_q == ST_ONE && acc && ret)) begin
        h_wdata_d = in_wdata;
        h_we_d    = cap_we;
        h_waddr_d = in_waddr;
      end else if (state_q == ST_ONE && acc && !ret) begin
        s_wdata_d = in_wdata;
        s_we_d    = cap_we;
        s_waddr_d = in_waddr;
      end else if (state_q == ST_FULL && ret) begin
        h_wdata_d = s_wdata_q;
        h_we_d    = s_we_q;
        h_waddr_d = s_waddr_q;
      end
    end
  end

  // A flushed cycle retires nothing, so it is not counted either
  always_comb begin
    cnt_d = cnt_q;
    if (!flush && ret && out_we) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_wdata_q <= '0;
      h_we_q    <= 1'b0;
      h_waddr_q <= '0;
      s_wdata_q <= '0;
      s_we_q    <= 1'b0;
      s_waddr_q <= '0;
      cnt_q     <= '0;
    end else begin
      h_wdata_q <= h_wdata_d;
      h_we_q    <= h_we_d;
      h_waddr_q <= h_waddr_d;
      s_wdata_q <= s_wdata_d;
      s_we_q    <= s_we_d;
      s_waddr_q <= s_waddr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign commit_cnt = cnt_q;

  // Skid entry is younger, so it wins when both match
  assign s_hit = s_vld & s_we_q & (s_waddr_q == lk_addr) & (lk_addr != '0);
  assign h_hit = h_vld & h_we_q & (h_waddr_q == lk_addr) & (lk_addr != '0);

  always_comb begin
    lk_hit  = s_hit | h_hit;
    lk_data = '0;
    if (s_hit)      lk_data = s_wdata_q;
    else if (h_hit) lk_data = h_wdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_skid.sv
// tb_mem_wb_skid: directed self-checking bench for mem_wb_skid.
`default_nettype none

module tb_mem_wb_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_we, out_valid, out_ready;
  logic        out_we, lk_hit;
  logic [31:0] in_wdata, out_wdata, lk_data, commit_cnt;
  logic [4:0]  in_waddr, out_waddr, lk_addr;

  int total = 0;
  int bad   = 0;

  mem_wb_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_wdata(in_wdata),
    .in_we(in_we), .in_waddr(in_waddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_wdata(out_wdata),
    .out_we(out_we), .out_waddr(out_waddr),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
    in_valid = v;
    in_waddr = a;
    in_wdata = d;
    in_we    = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; lk_addr = 5'd0;
    drive(1'b1, 5'd5, 32'h1234);
    tick; tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_waddr !== 5'd0) begin bad++; $display("FAIL rst_out_waddr got=%0d exp=0", out_waddr); end
    total++; if (out_we !== 1'b0 || out_wdata !== 32'd0) begin bad++; $display("FAIL rst_out_we_wdata got=%0b/%0h exp=0/0", out_we, out_wdata); end
    total++; if (commit_cnt !== 32'd0) begin bad++; $display("FAIL rst_commit got=%0d exp=0", commit_cnt); end
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_post_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 1), 32'hA0 + 32'(i));
      tick;
      total++;
      if (out_valid !== 1'b1 || out_waddr !== 5'(i + 1) || out_wdata !== 32'hA0 + 32'(i) || out_we !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d got v=%0b a=%0d d=%0h we=%0b exp v=1 a=%0d d=%0h we=1",
                 i, out_valid, out_waddr, out_wdata, out_we, i + 1, 32'hA0 + i);
      end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_%0d got=%0b exp=1", i, in_ready); end
    end
    drive(1'b0, 5'd0, 32'd0);
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b exp=0", out_valid); end
    total++; if (commit_cnt !== 32'd8) begin bad++; $display("FAIL stream_commit got=%0d exp=8", commit_cnt); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    drive(1'b1, 5'd9, 32'h101);
    tick;
    total++; if (in_ready !== 1'b1 || out_waddr !== 5'd9) begin bad++; $display("FAIL stall_one got rdy=%0b a=%0d exp rdy=1 a=9", in_ready, out_waddr); end
    drive(1'b1, 5'd10, 32'h102);
    tick;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_full_ready got=%0b exp=0", in_ready); end
    drive(1'b1, 5'd11, 32'h103);
    tick;
    total++; if (in_ready !== 1'b0 || out_waddr !== 5'd9 || out_wdata !== 32'h101) begin bad++; $display("FAIL stall_hold got rdy=%0b a=%0d d=%0h exp rdy=0 a=9 d=101", in_ready, out_waddr, out_wdata); end
    out_ready = 1'b1;
    tick;
    total++; if (in_ready !== 1'b1 || out_waddr !== 5'd10 || out_wdata !== 32'h102) begin bad++; $display("FAIL stall_ret1 got rdy=%0b a=%0d d=%0h exp rdy=1 a=10 d=102", in_ready, out_waddr, out_wdata); end
    tick;
    total++; if (out_valid !== 1'b1 || out_waddr !== 5'd11 || out_wdata !== 32'h103) begin bad++; $display("FAIL stall_ret2 got v=%0b a=%0d d=%0h exp v=1 a=11 d=103", out_valid, out_waddr, out_wdata); end
    drive(1'b0, 5'd0, 32'd0);
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%0b exp=0", out_valid); end
    total++; if (commit_cnt !== 32'd11) begin bad++; $display("FAIL stall_commit got=%0d exp=11", commit_cnt); end
  endtask

  task automatic test_zero_reg;
    out_ready = 1'b0;
    drive(1'b1, 5'd0, 32'hDEAD);
    tick;
    total++; if (out_valid !== 1'b1 || out_we !== 1'b0 || out_wdata !== 32'hDEAD || out_waddr !== 5'd0) begin
      bad++; $display("FAIL zero_head got v=%0b we=%0b d=%0h a=%0d exp v=1 we=0 d=dead a=0", out_valid, out_we, out_wdata, out_waddr);
    end
    drive(1'b0, 5'd0, 32'd0);
    out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_retire got=%0b exp=0", out_valid); end
    total++; if (commit_cnt !== 32'd11) begin bad++; $display("FAIL zero_commit got=%0d exp=11", commit_cnt); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 5'd12, 32'h55); tick;
    drive(1'b1, 5'd13, 32'h66); tick;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%0b exp=0", in_ready); end
    flush = 1'b1;
    drive(1'b1, 5'd14, 32'h77);
    tick;
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
    total++; if (commit_cnt !== 32'd11) begin bad++; $display("FAIL flush_commit got=%0d exp=11", commit_cnt); end
    lk_addr = 5'd14; #1;
    total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL flush_lk got=%0b exp=0", lk_hit); end
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_nocap got=%0b exp=0", out_valid); end
  endtask

  task automatic test_forward;
    out_ready = 1'b0;
    lk_addr = 5'd3;
    drive(1'b1, 5'd3, 32'h11); tick;
    total++; if (lk_hit !== 1'b1 || lk_data !== 32'h11) begin bad++; $display("FAIL fwd_one got hit=%0b d=%0h exp hit=1 d=11", lk_hit, lk_data); end
    drive(1'b1, 5'd3, 32'h22); tick;
    drive(1'b0, 5'd0, 32'd0);
    total++; if (lk_hit !== 1'b1 || lk_data !== 32'h22) begin bad++; $display("FAIL fwd_full got hit=%0b d=%0h exp hit=1 d=22", lk_hit, lk_data); end
    lk_addr = 5'd0; #1;
    total++; if (lk_hit !== 1'b0 || lk_data !== 32'd0) begin bad++; $display("FAIL fwd_zero_full got hit=%0b d=%0h exp hit=0 d=0", lk_hit, lk_data); end
    lk_addr = 5'd4; #1;
    total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL fwd_miss got=%0b exp=0", lk_hit); end
    lk_addr = 5'd3;
    out_ready = 1'b1;
    tick;
    total++; if (lk_hit !== 1'b1 || lk_data !== 32'h22) begin bad++; $display("FAIL fwd_ret1 got hit=%0b d=%0h exp hit=1 d=22", lk_hit, lk_data); end
    tick;
    total++; if (lk_hit !== 1'b0 || lk_data !== 32'd0) begin bad++; $display("FAIL fwd_ret2 got hit=%0b d=%0h exp hit=0 d=0", lk_hit, lk_data); end
    total++; if (commit_cnt !== 32'd13) begin bad++; $display("FAIL fwd_commit got=%0d exp=13", commit_cnt); end
    lk_addr = 5'd0; #1;
    total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL fwd_zero_empty got=%0b exp=0", lk_hit); end
  endtask

  initial begin
    test_reset;
    test_streaming;
    test_stall;
    test_zero_reg;
    test_flush;
    test_forward;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_wb_skid.md
# mem_wb_skid

Parametrised MEM/WB pipeline stage that replaces a plain always-advancing stage register with a ready/valid handshake. It uses a two-entry skid buffer so the write-back stage can stall without creating a combinational ready path back into MEM. It also supports a synchronous flush, suppresses writes to the zero register, and provides a forwarding lookup across both held entries. It sits between the MEM stage and the register-file write port, and counts committed writes for performance monitoring.

## Interface
- DATA_W, 32, width of write-back data
- ADDR_W, 5, width of register address
- NOP_ADDR, 0, register address driven when no valid write is presented
- CNT_W, 32, width of committed-write counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous flush; discards all held entries
- in_valid  in  1  MEM presents a write-back bundle
- in_ready  out  1  stage can accept a bundle this cycle
- in_wdata  in  DATA_W  write-back data
- in_we  in  1  register write enable
- in_waddr  in  ADDR_W  destination register
- out_valid  out  1  bundle presented to write-back
- out_ready  in  1  write-back consumes the bundle this cycle
- out_wdata  out  DATA_W  head data
- out_we  out  1  head write enable, 0 whenever out_valid=0
- out_waddr  out  ADDR_W  head address, NOP_ADDR whenever out_valid=0
- lk_addr  in  ADDR_W  forwarding lookup address
- lk_hit  out  1  a held valid entry writes lk_addr
- lk_data  out  DATA_W  data of the youngest matching entry, 0 if no hit
- commit_cnt  out  CNT_W  number of bundles retired with out_we=1

## Operation
- Storage:
  - head register H (valid, wdata, we, waddr) drives out_*;
  - skid register S holds the younger entry.
- State is encoded by {S.valid, H.valid}:
  - EMPTY (0,0)
  - ONE (0,1)
  - FULL (1,1)
  - (1,0) is illegal and never reached.
- in_ready = !S.valid. It is decoded from registered state, with no combinational path from out_ready.
- Accept: acc = in_valid & in_ready.
- Retire: ret = out_valid & out_ready.
- Capture rule: the stored we = in_we & (in_waddr != 0), so writes to register 0 are dropped. The entry itself still flows and still needs a handshake.
- Transitions, when not flushing:
  - EMPTY, acc → ONE; H ← input.
  - ONE, acc & ret → ONE; H ← input.
  - ONE, acc & !ret → FULL; S ← input.
  - ONE, !acc & ret → EMPTY.
  - FULL, ret → ONE; H ← S, S.valid ← 0. No accept is possible because in_ready=0.
  - Any state with neither acc nor ret holds.
- Flush has priority over acc and ret. It forces EMPTY, and in_valid is ignored that cycle.
- While out_valid=0, out_wdata, out_we and out_waddr are forced to 0, 0 and NOP_ADDR.
- Lookup (combinational):
  - lk_hit when a valid entry has we=1 and waddr==lk_addr.
  - Priority is S over H (S is younger).
  - lk_addr=0 never hits.
- commit_cnt increments by 1 on ret & out_we. It wraps modulo 2^CNT_W and is not cleared by flush.

## Timing
- Reset values:
  - out_valid=0, out_wdata=0, out_we=0, out_waddr=NOP_ADDR;
  - commit_cnt=0, state EMPTY.
  - in_ready=1 in the cycle after reset deasserts. Inputs are ignored while rst=1.
- Latency: a bundle accepted at edge N is on out_* in cycle N+1 if the stage was EMPTY, or if it was ONE with a simultaneous retire.
- Throughput is 1 bundle/cycle with out_ready held high. After a single stall cycle, in_ready drops for exactly one cycle, the cycle after the stage fills.
- Reset or flush asserted mid-operation drops both entries at that edge. No partial write is ever presented.
- Outputs on out_* change only at clock edges. Only lk_hit and lk_data are combinational, and only from lk_addr and registered state.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, out_waddr=0, commit_cnt=0, in_ready=1 after release.
- Streaming: 8 bundles (waddr 1..8, wdata 0xA0+i, we=1) with out_ready=1 → same order, 1-cycle latency, commit_cnt=8.
- Stall/skid:
  - Stimulus: out_ready=0 while pushing 3 bundles.
  - Required: 2 accepted (FULL), third held with in_ready=0.
  - Release out_ready: all 3 retire in order with no loss or duplicate.
- Zero register: bundle waddr=0, we=1, wdata=0xDEAD → out_valid=1, out_we=0, commit_cnt unchanged.
- Flush:
  - Stimulus: FULL state, flush=1 together with in_valid=1.
  - Required: next cycle out_valid=0, in_ready=1, new bundle not captured, commit_cnt retained.
- Forwarding:
  - Stimulus: FULL with H=(r3,0x11) and S=(r3,0x22), then lk_addr=3.
  - Required: lk_hit=1, lk_data=0x22.
  - After one retire: 0x22. After a second retire: lk_hit=0, lk_data=0.
  - lk_addr=0: lk_hit=0 in all states.
